mem_stage_seq: RTL and testbench
================================

MEM_STAGE_SEQ -- requirements
Module: mem_stage_seq

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles spent in REQ+WAIT before abort.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid/in_ready  input/output  1/1  upstream (EX/MEM) handshake.
REQ-006 in_is_load, in_is_store, in_is_flush  input  1 each  operation kind; all zero means pass-through.
REQ-007 in_size  input  2  0=byte, 1=half, 2=word, 3=dword; in_signed  input  1  sign-extend loads.
REQ-008 in_addr, in_wdata, in_alu  input  XLEN each  effective address, store data, ALU result.
REQ-009 out_valid/out_ready  output/input  1/1  downstream (MEM/WB) handshake.
REQ-010 out_data  output  XLEN  load result or in_alu; out_fault, out_timeout  output  1 each.
REQ-011 req_valid/req_ready  output/input  1/1  cache request; req_we  output  1; req_size  output  2.
REQ-012 req_addr, req_wdata  output  XLEN each; rsp_valid  input  1; rsp_data  input  XLEN aligned word.
REQ-013 flush_req  output  1; flush_done  input  1; snoop_stall  input  1.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, FLUSH, DONE.
REQ-015 in_ready SHALL equal (state==IDLE && !snoop_stall); an op is accepted when in_valid && in_ready.
REQ-016 Pass-through op: IDLE->DONE, out_data=in_alu, out_valid exactly 1 cycle after acceptance.
REQ-017 Load/store: IDLE->REQ; req_valid held with stable payload until req_ready; then REQ->WAIT.
REQ-018 In WAIT, rsp_valid SHALL capture the result and move to DONE; stores also wait for rsp_valid (write ack).
REQ-019 Minimum load latency: acceptance at N, req at N+1, rsp at N+2 gives out_valid at N+3.
REQ-020 Loads SHALL extract lane in_addr[log2(XLEN/8)-1:0] from rsp_data and sign- or zero-extend per in_signed/in_size.
REQ-021 Stores SHALL drive req_wdata with in_wdata's low bytes shifted to the addressed lane; req_size=in_size.
REQ-022 Flush: IDLE->FLUSH, flush_req held high until flush_done, then DONE with out_data=0.
REQ-023 DONE SHALL hold out_valid and outputs until out_ready; then IDLE; no new acceptance in the same cycle.
REQ-024 in_size=3 with XLEN=32 SHALL go directly to DONE with out_fault=1 and no cache request.
REQ-025 Timeout counter clears on entry to REQ; reaching TIMEOUT-1 in REQ/WAIT SHALL force DONE, out_timeout=1, out_data=0.
REQ-026 snoop_stall SHALL only block acceptance; a req_valid already raised SHALL NOT be withdrawn.
REQ-027 rsp_valid or flush_done outside WAIT/FLUSH SHALL be ignored.
REQ-028 More than one of in_is_load/store/flush set SHALL produce out_fault=1 with no cache activity.

Reset
REQ-029 Reset SHALL force IDLE, and clear out_valid, req_valid, flush_req, out_fault, out_timeout, out_data and the timeout counter.
REQ-030 Reset mid-operation SHALL abandon the op; a later stale rsp_valid SHALL be ignored per REQ-027.

Configuration
REQ-031 With macro MEM_MISALIGN_TRAP_EN defined, an access whose in_addr is not size-aligned SHALL go to DONE with out_fault=1 and no request.
REQ-032 Without MEM_MISALIGN_TRAP_EN, misaligned accesses SHALL be issued unchanged and out_fault SHALL only reflect REQ-024/REQ-028.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the size encodings and the lane-extract/extend function.
REQ-034 Load alignment/extension SHALL be one sub-module, mem_load_align (combinational); the FSM stays in mem_stage_seq.

Verification
REQ-035 Load in_addr=0x1003, size=0, signed=1, rsp_data=0x0000_0000_8000_0000 -> out_data=0xFFFF_FFFF_FFFF_FF80, out_valid at N+3.
REQ-036 Store in_addr=0x2004, size=2, in_wdata=0x1234_5678, req_ready held low 3 cycles -> req_valid and payload stable for 4 cycles, req_wdata=0x1234_5678_0000_0000.
REQ-037 Pass-through in_alu=0x55 with out_ready low 2 cycles -> out_valid held 3 cycles with out_data=0x55, in_ready low throughout.
REQ-038 TIMEOUT=8 load with rsp_valid never asserted -> out_timeout=1, out_data=0 after 8 cycles in REQ/WAIT.
REQ-039 Flush with flush_done at +5 and snoop_stall high in IDLE -> flush_req high 5 cycles, in_ready low while stalled.
REQ-040 MEM_MISALIGN_TRAP_EN defined, load in_addr=0x1001, size=1 -> out_fault=1 at N+1, req_valid never asserted.

Source files
------------

// File: rtl/mem_stage_seq_pkg.sv
// Shared types and helpers for the memory stage: FSM states, access size
// encodings, and the byte-lane functions used for loads and stores.
// Lane math is done at 64 bits; narrower datapaths widen and truncate.
package mem_stage_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    localparam int LANE_W = 64;

    // Pull the addressed lane out of an aligned word and extend it to 64 bits.
    function automatic logic [LANE_W-1:0] lane_extend(
        input logic [LANE_W-1:0] data,
        input logic [2:0]        off,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [LANE_W-1:0] sh;
        logic [LANE_W-1:0] res;
        sh = data >> {off, 3'b000};
        case (size_e'(size))
            SZ_BYTE: res = {{56{sgn & sh[7]}},  sh[7:0]};
            SZ_HALF: res = {{48{sgn & sh[15]}}, sh[15:0]};
            SZ_WORD: res = {{32{sgn & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Keep the low bytes of the store data for this size and move them to the lane.
    function automatic logic [LANE_W-1:0] store_shift(
        input logic [LANE_W-1:0] wdata,
        input logic [2:0]        off,
        input logic [1:0]        size
    );
        logic [LANE_W-1:0] masked;
        case (size_e'(size))
            SZ_BYTE: masked = {56'd0, wdata[7:0]};
            SZ_HALF: masked = {48'd0, wdata[15:0]};
            SZ_WORD: masked = {32'd0, wdata[31:0]};
            default: masked = wdata;
        endcase
        return masked << {off, 3'b000};
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned(
        input logic [2:0] addr_lo,
        input logic [1:0] size
    );
        logic res;
        case (size_e'(size))
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = addr_lo[0];
            SZ_WORD: res = |addr_lo[1:0];
            default: res = |addr_lo;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_seq_if.sv
// Cache-side bus of the memory stage: request channel, response, flush.
// master = memory stage, slave = cache / memory model.
interface mem_stage_seq_if #(
    parameter int XLEN = 64
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            flush_req;
    logic            flush_done;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, flush_req,
        input  req_ready, rsp_valid, rsp_data, flush_done
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, flush_req,
        output req_ready, rsp_valid, rsp_data, flush_done
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: selects the addressed lane of the returned
// word and sign- or zero-extends it to XLEN.
module mem_load_align
    import mem_stage_seq_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rsp_data_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [1:0]       size_i,
    input  logic             signed_i,
    output logic [XLEN-1:0]  data_o
);

    logic [LANE_W-1:0] res_wide;

    // Widen to the package lane width, extract and extend, then truncate.
    always_comb begin
        res_wide = lane_extend(LANE_W'(rsp_data_i), 3'(off_i), size_i, signed_i);
    end

    assign data_o = res_wide[XLEN-1:0];

endmodule

// File: rtl/mem_stage_seq.sv
// Memory pipeline stage sequencer: accepts one op from EX/MEM, issues a
// cache load/store or a flush, and hands the result to MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned loads/stores fault
// without a cache request instead of being issued unchanged.
module mem_stage_seq
    import mem_stage_seq_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic            in_is_flush,
    input  logic [1:0]      in_size,
    input  logic            in_signed,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_alu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_fault,
    output logic            out_timeout,
    input  logic            snoop_stall,
    mem_stage_seq_if.master cache
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_fault_q, out_fault_d;
    logic            out_timeout_q, out_timeout_d;

    // Captured op payload (datapath, not reset)
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      size_q;
    logic            signed_q;
    logic            we_q;

    logic            accept;
    logic            mem_op;
    logic            pass_op;
    logic            multi_op;
    logic            size_fault;
    logic            misalign_fault;
    logic            decode_fault;
    logic            timeout_hit;
    logic [XLEN-1:0] load_data;
    logic [LANE_W-1:0] store_wide;

    assign accept      = in_valid && in_ready;
    assign mem_op      = in_is_load || in_is_store;
    assign pass_op     = !(in_is_load || in_is_store || in_is_flush);
    assign multi_op    = (in_is_load && in_is_store) || (in_is_load && in_is_flush) ||
                         (in_is_store && in_is_flush);
    assign size_fault  = (XLEN == 32) && mem_op && (in_size == SZ_DWORD);
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_fault = mem_op && misaligned(in_addr[2:0], in_size);
`else
    assign misalign_fault = 1'b0;
`endif
    assign decode_fault = multi_op || size_fault || misalign_fault;
    assign timeout_hit  = (cnt_q == CNT_MAX);
    assign store_wide   = store_shift(LANE_W'(in_wdata), 3'(in_addr[OFF_W-1:0]), in_size);

    mem_load_align #(
        .XLEN (XLEN),
        .OFF_W(OFF_W)
    ) u_load_align (
        .rsp_data_i(cache.rsp_data),
        .off_i     (addr_q[OFF_W-1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .data_o    (load_data)
    );

    // Control state: FSM, timeout counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_fault_q   <= 1'b0;
            out_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_fault_q   <= out_fault_d;
            out_timeout_q <= out_timeout_d;
        end
    end

    // Latch the request payload when an op is accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= in_addr;
            wdata_q  <= store_wide[XLEN-1:0];
            size_q   <= in_size;
            signed_q <= in_signed;
            we_q     <= in_is_store;
        end
    end

    // Next-state logic; timeout takes priority over a same-cycle handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (decode_fault)     state_d = ST_DONE;
                    else if (in_is_flush) state_d = ST_FLUSH;
                    else if (mem_op)      state_d = ST_REQ;
                    else                  state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                if (timeout_hit)          state_d = ST_DONE;
                else if (cache.req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (timeout_hit || cache.rsp_valid) state_d = ST_DONE;
            end
            ST_FLUSH: begin
                if (cache.flush_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result and counter updates; the counter restarts on every acceptance
    always_comb begin
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_fault_d   = out_fault_q;
        out_timeout_d = out_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d         = '0;
                    out_data_d    = pass_op ? in_alu : '0;
                    out_fault_d   = decode_fault;
                    out_timeout_d = 1'b0;
                end
            end
            ST_REQ, ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    out_timeout_d = 1'b1;
                    out_data_d    = '0;
                end else if ((state_q == ST_WAIT) && cache.rsp_valid) begin
                    out_data_d = we_q ? '0 : load_data;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready        = (state_q == ST_IDLE) && !snoop_stall;
        out_valid       = (state_q == ST_DONE);
        cache.req_valid = (state_q == ST_REQ);
        cache.flush_req = (state_q == ST_FLUSH);
    end

    assign cache.req_we    = we_q;
    assign cache.req_size  = size_q;
    assign cache.req_addr  = addr_q;
    assign cache.req_wdata = wdata_q;
    assign out_data        = out_data_q;
    assign out_fault       = out_fault_q;
    assign out_timeout     = out_timeout_q;

endmodule

// File: tb/tb_mem_stage_seq.sv
// Directed bench for mem_stage_seq (XLEN=64, TIMEOUT=8).
module tb_mem_stage_seq;
    import mem_stage_seq_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_is_load = 1'b0;
    logic            in_is_store = 1'b0;
    logic            in_is_flush = 1'b0;
    logic [1:0]      in_size = 2'd0;
    logic            in_signed = 1'b0;
    logic [XLEN-1:0] in_addr = '0;
    logic [XLEN-1:0] in_wdata = '0;
    logic [XLEN-1:0] in_alu = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_data;
    logic            out_fault;
    logic            out_timeout;
    logic            snoop_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] LD_ADDR [5] = '{64'h1003, 64'h1002, 64'h1004, 64'h1000, 64'h1007};
    localparam logic [1:0]  LD_SIZE [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic        LD_SGN  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [63:0] LD_RSP  [5] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                                            64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF,
                                            64'h8100_0000_0000_0000};
    localparam logic [63:0] LD_EXP  [5] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_8000,
                                            64'hFFFF_FFFF_DEAD_BEEF, 64'h0123_4567_89AB_CDEF,
                                            64'h0000_0000_0000_0081};

    mem_stage_seq_if #(.XLEN(XLEN)) cif ();

    mem_stage_seq #(
        .XLEN   (XLEN),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_load (in_is_load),
        .in_is_store(in_is_store),
        .in_is_flush(in_is_flush),
        .in_size    (in_size),
        .in_signed  (in_signed),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_alu     (in_alu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_fault  (out_fault),
        .out_timeout(out_timeout),
        .snoop_stall(snoop_stall),
        .cache      (cif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic l, input logic s, input logic f, input logic [1:0] sz,
                            input logic sg, input logic [63:0] a, input logic [63:0] wd,
                            input logic [63:0] alu);
        in_valid    = 1'b1;
        in_is_load  = l;
        in_is_store = s;
        in_is_flush = f;
        in_size     = sz;
        in_signed   = sg;
        in_addr     = a;
        in_wdata    = wd;
        in_alu      = alu;
    endtask

    task automatic drop_op();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_is_flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (cif.req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", cif.req_valid); end
        checks++; if (cif.flush_req !== 1'b0) begin errors++; $display("FAIL rst_flush_req: got %b want 0", cif.flush_req); end
        checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL rst_out_fault: got %b want 0", out_fault); end
        checks++; if (out_timeout !== 1'b0) begin errors++; $display("FAIL rst_out_timeout: got %b want 0", out_timeout); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 5; i++) begin
            drive_op(1'b1, 1'b0, 1'b0, LD_SIZE[i], LD_SGN[i], LD_ADDR[i], 64'd0, 64'hBAD);
            step();
            drop_op();
            // N+1: request raised
            checks++; if (cif.req_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_req_valid: got %b want 1", i, cif.req_valid); end
            checks++; if (cif.req_addr !== LD_ADDR[i]) begin errors++; $display("FAIL ld%0d_req_addr: got %h want %h", i, cif.req_addr, LD_ADDR[i]); end
            checks++; if (cif.req_we !== 1'b0) begin errors++; $display("FAIL ld%0d_req_we: got %b want 0", i, cif.req_we); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_early1: got %b want 0", i, out_valid); end
            cif.req_ready = 1'b1;
            step();
            cif.req_ready = 1'b0;
            // N+2: waiting for response
            checks++; if (cif.req_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_req_drop: got %b want 0", i, cif.req_valid); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_early2: got %b want 0", i, out_valid); end
            cif.rsp_valid = 1'b1;
            cif.rsp_data  = LD_RSP[i];
            step();
            cif.rsp_valid = 1'b0;
            cif.rsp_data  = '0;
            // N+3: result presented
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_out_valid: got %b want 1", i, out_valid); end
            checks++; if (out_data !== LD_EXP[i]) begin errors++; $display("FAIL ld%0d_out_data: got %h want %h", i, out_data, LD_EXP[i]); end
            checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL ld%0d_out_fault: got %b want 0", i, out_fault); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld%0d_back_idle: got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_store();
        drive_op(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h2004, 64'hAAAA_AAAA_1234_5678, 64'd0);
        step();
        drop_op();
        for (int i = 0; i < 4; i++) begin
            snoop_stall = (i == 1);
            #1;
            checks++; if (cif.req_valid !== 1'b1) begin errors++; $display("FAIL st_req_valid[%0d]: got %b want 1", i, cif.req_valid); end
            checks++; if (cif.req_wdata !== 64'h1234_5678_0000_0000) begin errors++; $display("FAIL st_req_wdata[%0d]: got %h want 1234567800000000", i, cif.req_wdata); end
            checks++; if (cif.req_addr !== 64'h2004) begin errors++; $display("FAIL st_req_addr[%0d]: got %h want 2004", i, cif.req_addr); end
            checks++; if (cif.req_size !== 2'd2 || cif.req_we !== 1'b1) begin errors++; $display("FAIL st_req_ctl[%0d]: got size %0d we %b want size 2 we 1", i, cif.req_size, cif.req_we); end
            if (i == 3) cif.req_ready = 1'b1;
            step();
        end
        snoop_stall   = 1'b0;
        cif.req_ready = 1'b0;
        checks++; if (cif.req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL st_wait: got req_valid %b out_valid %b want 0 0", cif.req_valid, out_valid); end
        cif.rsp_valid = 1'b1;
        step();
        cif.rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 64'd0) begin errors++; $display("FAIL st_done: got valid %b data %h want 1 0", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_passthrough();
        drive_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h55);
        step();
        drop_op();
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_out_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== 64'h55) begin errors++; $display("FAIL pt_out_data[%0d]: got %h want 55", i, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pt_in_ready[%0d]: got %b want 0", i, in_ready); end
            if (i == 2) out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL pt_release: got valid %b in_ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h11);
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h11) begin errors++; $display("FAIL b2b_first: got valid %b data %h want 1 11", out_valid, out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_in_done: got %b want 0", in_ready); end
        in_alu = 64'h22;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got valid %b in_ready %b want 0 1", out_valid, in_ready); end
        step();
        drop_op();
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h22) begin errors++; $display("FAIL b2b_second: got valid %b data %h want 1 22", out_valid, out_data); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc;
        drive_op(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 64'h3000, 64'h0, 64'h0);
        step();
        drop_op();
        cif.req_ready = 1'b1;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            cyc++;
            step();
            cif.req_ready = 1'b0;
        end
        checks++; if (cyc != 8) begin errors++; $display("FAIL to_cycles: got %0d want 8", cyc); end
        checks++; if (out_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", out_timeout); end
        checks++; if (out_data !== 64'd0 || out_fault !== 1'b0) begin errors++; $display("FAIL to_data: got data %h fault %b want 0 0", out_data, out_fault); end
        cif.rsp_valid = 1'b1;
        cif.rsp_data  = 64'hFFFF_0000_FFFF_0000;
        step();
        checks++; if (out_data !== 64'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL to_stale_rsp: got valid %b data %h want 1 0", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        cif.rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cif.req_valid !== 1'b0) begin errors++; $display("FAIL to_idle_ignore: got valid %b in_ready %b req %b want 0 1 0", out_valid, in_ready, cif.req_valid); end
    endtask

    task automatic test_flush();
        int hi;
        snoop_stall = 1'b1;
        drive_op(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 64'h0, 64'h0, 64'h77);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (in_ready !== 1'b0 || cif.flush_req !== 1'b0) begin errors++; $display("FAIL fl_stalled[%0d]: got in_ready %b flush_req %b want 0 0", i, in_ready, cif.flush_req); end
            step();
        end
        snoop_stall = 1'b0;
        step();
        drop_op();
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (cif.flush_req === 1'b1) hi++;
            if (i == 4) cif.flush_done = 1'b1;
            step();
        end
        cif.flush_done = 1'b0;
        checks++; if (hi != 5) begin errors++; $display("FAIL fl_req_cycles: got %0d want 5", hi); end
        checks++; if (cif.flush_req !== 1'b0) begin errors++; $display("FAIL fl_req_drop: got %b want 0", cif.flush_req); end
        checks++; if (out_valid !== 1'b1 || out_data !== 64'd0) begin errors++; $display("FAIL fl_done: got valid %b data %h want 1 0", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        cif.flush_done = 1'b1;
        step();
        cif.flush_done = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_stray_done: got valid %b in_ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_fault();
        drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h4000, 64'h0, 64'h99);
        step();
        drop_op();
        checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1) begin errors++; $display("FAIL ft_multi: got valid %b fault %b want 1 1", out_valid, out_fault); end
        checks++; if (cif.req_valid !== 1'b0 || cif.flush_req !== 1'b0) begin errors++; $display("FAIL ft_no_cache: got req %b flush %b want 0 0", cif.req_valid, cif.flush_req); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_misalign();
        drive_op(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 64'h1001, 64'h0, 64'h0);
        step();
        drop_op();
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1) begin errors++; $display("FAIL ma_trap: got valid %b fault %b want 1 1", out_valid, out_fault); end
        checks++; if (cif.req_valid !== 1'b0) begin errors++; $display("FAIL ma_no_req: got %b want 0", cif.req_valid); end
`else
        checks++; if (cif.req_valid !== 1'b1 || cif.req_addr !== 64'h1001) begin errors++; $display("FAIL ma_issue: got req %b addr %h want 1 1001", cif.req_valid, cif.req_addr); end
        cif.req_ready = 1'b1;
        step();
        cif.req_ready = 1'b0;
        cif.rsp_valid = 1'b1;
        cif.rsp_data  = 64'h0000_0000_00AB_CD00;
        step();
        cif.rsp_valid = 1'b0;
        checks++; if (out_data !== 64'hABCD || out_fault !== 1'b0) begin errors++; $display("FAIL ma_data: got data %h fault %b want abcd 0", out_data, out_fault); end
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 64'h5000, 64'h0, 64'h0);
        step();
        drop_op();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (cif.req_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_abandon: got req %b in_ready %b valid %b want 0 1 0", cif.req_valid, in_ready, out_valid); end
        cif.rsp_valid = 1'b1;
        cif.rsp_data  = 64'h1234;
        step();
        cif.rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin errors++; $display("FAIL rm_stale_rsp: got valid %b data %h want 0 0", out_valid, out_data); end
    endtask

    initial begin
        cif.req_ready  = 1'b0;
        cif.rsp_valid  = 1'b0;
        cif.rsp_data   = '0;
        cif.flush_done = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_passthrough();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_fault();
        test_misalign();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
